// File: rtl/avalon_parallel_port_if.sv
// Avalon-MM slave bus bundle for the parallel I/O port.
// The master modport is the bus side (CPU or bench); the slave modport is the port block.
interface avalon_parallel_port_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, read, write, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, read, write, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/avalon_parallel_port.sv
// Parametrised Avalon-MM parallel I/O port: per-bit direction, synchronised and
// optionally debounced inputs, rising/falling edge capture and a maskable level irq.
module avalon_parallel_port #(
  parameter int          WIDTH           = 32,
  parameter int          DEBOUNCE_CYCLES = 0,
  parameter logic [31:0] RESET_DIR       = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  avalon_parallel_port_if.slave bus,
  inout  wire  [WIDTH-1:0]      pins
);

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [31:0]      readdata_q;

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;
  logic [WIDTH-1:0] deb_p2;
  logic [WIDTH-1:0] prev_p3;

  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] set_mask;
  logic [WIDTH-1:0] rd_mux;
  logic             unused_wdata;

  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  assign wr_en        = bus.chipselect & bus.write;
  assign rd_en        = bus.chipselect & bus.read;
  assign wdata        = bus.writedata[WIDTH-1:0];
  assign unused_wdata = ^bus.writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign pins[i] = dir[i] ? data_out[i] : 1'bz;
  end

  // Register file writes
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= '0;
      dir      <= RESET_DIR[WIDTH-1:0];
      irq_mask <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
    end else if (wr_en) begin
      case (bus.address)
        3'd0:    data_out <= wdata;
        3'd1:    dir      <= wdata;
        3'd2:    irq_mask <= wdata;
        3'd4:    rise_en  <= wdata;
        3'd5:    fall_en  <= wdata;
        default: ;
      endcase
    end
  end

  // Stage p0/p1: two-flop synchroniser, free-running even in reset
  always_ff @(posedge clk) begin
    sync_p0 <= pins;
    sync_p1 <= sync_p0;
  end

  // Stage p2: debounced level
  if (DEBOUNCE_CYCLES == 0) begin : g_no_deb
    assign deb_p2 = sync_p1;
  end else begin : g_deb
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt [WIDTH];
    logic [WIDTH-1:0] deb_q;

    // The counter only runs while the synchronised level disagrees, so any
    // bounce back to the old level restarts the stable-period count.
    always_ff @(posedge clk) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (reset) begin
          cnt[i]   <= '0;
          deb_q[i] <= sync_p1[i];
        end else if (sync_p1[i] == deb_q[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt[i]   <= '0;
          deb_q[i] <= sync_p1[i];
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end

    assign deb_p2 = deb_q;
  end

  // Stage p3: previous debounced level for edge detection
  always_ff @(posedge clk) begin
    if (reset) prev_p3 <= sync_p1;
    else       prev_p3 <= deb_p2;
  end

  assign set_mask = ((deb_p2 & ~prev_p3) & rise_en) | ((~deb_p2 & prev_p3) & fall_en);
  assign clr_mask = (wr_en && bus.address == 3'd3) ? wdata : '0;

  // A new event on the same edge as a write-1-clear keeps the bit set.
  always_ff @(posedge clk) begin
    if (reset) edge_cap <= '0;
    else       edge_cap <= (edge_cap & ~clr_mask) | set_mask;
  end

  assign bus.irq = |(edge_cap & irq_mask);

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      3'd0:    rd_mux = (dir & data_out) | (~dir & deb_p2);
      3'd1:    rd_mux = dir;
      3'd2:    rd_mux = irq_mask;
      3'd3:    rd_mux = edge_cap;
      3'd4:    rd_mux = rise_en;
      3'd5:    rd_mux = fall_en;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)      readdata_q <= '0;
    else if (rd_en) readdata_q <= zext(rd_mux);
  end

  assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_avalon_parallel_port.sv
// Scoreboarded directed bench: two port instances (no debounce, 4-cycle debounce)
// with read expectations queued at issue time and checked by per-instance monitors.
module tb_avalon_parallel_port;

  typedef struct {
    string       nm;
    logic [31:0] v;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst4;
  avalon_parallel_port_if bus0 ();
  avalon_parallel_port_if bus4 ();

  wire  [7:0] pins0, pins4;
  logic [7:0] drv_en0, drv_val0, drv_en4, drv_val4;

  for (genvar i = 0; i < 8; i++) begin : g_drv
    assign pins0[i] = drv_en0[i] ? drv_val0[i] : 1'bz;
    assign pins4[i] = drv_en4[i] ? drv_val4[i] : 1'bz;
  end

  avalon_parallel_port #(.WIDTH(8), .DEBOUNCE_CYCLES(0), .RESET_DIR(32'h0F)) u_dut0 (
    .clk(clk), .reset(rst0), .bus(bus0), .pins(pins0)
  );

  avalon_parallel_port #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .RESET_DIR(32'h00)) u_dut4 (
    .clk(clk), .reset(rst4), .bus(bus4), .pins(pins4)
  );

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q0[$];
  exp_t exp_q4[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Read-data monitors: a read accepted on an edge is compared just after it.
  initial forever begin
    @(posedge clk);
    if (bus0.chipselect && bus0.read) begin
      #1;
      if (exp_q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd0_unexpected: got %h expected none", bus0.readdata);
      end else begin
        exp_t e;
        e = exp_q0.pop_front();
        check(e.nm, bus0.readdata, e.v);
      end
    end
  end

  initial forever begin
    @(posedge clk);
    if (bus4.chipselect && bus4.read) begin
      #1;
      if (exp_q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd4_unexpected: got %h expected none", bus4.readdata);
      end else begin
        exp_t e;
        e = exp_q4.pop_front();
        check(e.nm, bus4.readdata, e.v);
      end
    end
  end

  task automatic bus_op(input int sel, input bit wr, input logic [2:0] a,
                        input logic [31:0] d, input string nm);
    if (sel == 0) begin
      bus0.address = a; bus0.chipselect = 1'b1; bus0.read = !wr; bus0.write = wr;
      bus0.writedata = wr ? d : 32'h0;
      if (!wr) exp_q0.push_back('{nm, d});
    end else begin
      bus4.address = a; bus4.chipselect = 1'b1; bus4.read = !wr; bus4.write = wr;
      bus4.writedata = wr ? d : 32'h0;
      if (!wr) exp_q4.push_back('{nm, d});
    end
    @(posedge clk);
    #1;
    bus0.chipselect = 1'b0; bus0.read = 1'b0; bus0.write = 1'b0;
    bus4.chipselect = 1'b0; bus4.read = 1'b0; bus4.write = 1'b0;
  endtask

  task automatic wr(input int sel, input logic [2:0] a, input logic [31:0] d);
    bus_op(sel, 1'b1, a, d, "");
  endtask

  task automatic rd(input int sel, input logic [2:0] a, input logic [31:0] req, input string nm);
    bus_op(sel, 1'b0, a, req, nm);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus0.address = '0; bus0.chipselect = 1'b0; bus0.read = 1'b0; bus0.write = 1'b0; bus0.writedata = '0;
    bus4.address = '0; bus4.chipselect = 1'b0; bus4.read = 1'b0; bus4.write = 1'b0; bus4.writedata = '0;
    drv_en0 = 8'hF0; drv_val0 = 8'h00;
    drv_en4 = 8'hFF; drv_val4 = 8'h00;
    rst0 = 1'b1; rst4 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst0 = 1'b0; rst4 = 1'b0;

    // Reset defaults
    check("rst_readdata", bus0.readdata, 32'h0);
    check("rst_irq0", {31'b0, bus0.irq}, 32'h0);
    check("rst_irq4", {31'b0, bus4.irq}, 32'h0);
    rd(0, 3'd0, 32'h00, "rst_data");
    rd(0, 3'd1, 32'h0F, "rst_dir");
    rd(0, 3'd2, 32'h00, "rst_mask");
    rd(0, 3'd3, 32'h00, "rst_cap");
    rd(0, 3'd4, 32'h00, "rst_rise");
    rd(0, 3'd5, 32'h00, "rst_fall");
    rd(4, 3'd1, 32'h00, "rst_dir4");

    // Upper nibble is released: an external level on it is read back as input
    drv_val0 = 8'hA0;
    cycles(3);
    rd(0, 3'd0, 32'hA0, "in_upper");

    // Reserved addresses read 0 even after a write
    wr(0, 3'd6, 32'hFFFF_FFFF);
    rd(0, 3'd6, 32'h00, "rsvd6");
    rd(0, 3'd7, 32'h00, "rsvd7");

    // Output path
    drv_en0 = 8'h00; drv_val0 = 8'h00;
    wr(0, 3'd1, 32'hFF);
    wr(0, 3'd0, 32'hA5);
    check("pins_out", {24'b0, pins0}, 32'hA5);
    rd(0, 3'd0, 32'hA5, "data_out");
    rd(0, 3'd1, 32'hFF, "dir_ff");
    wr(0, 3'd1, 32'hFFFF_FF3C);
    rd(0, 3'd1, 32'h3C, "dir_width");

    // Hand the pins back to the bench as inputs, all low
    wr(0, 3'd0, 32'h00);
    drv_en0 = 8'hFF;
    wr(0, 3'd1, 32'h00);
    cycles(4);

    // Rising capture, D = 0
    wr(0, 3'd4, 32'h01);
    wr(0, 3'd2, 32'h01);
    rd(0, 3'd3, 32'h00, "cap_idle");
    drv_val0[0] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("irq_e1", {31'b0, bus0.irq}, 32'h0);
    @(posedge clk);
    #1;
    check("irq_e2", {31'b0, bus0.irq}, 32'h1);
    rd(0, 3'd3, 32'h01, "cap_rise");
    wr(0, 3'd3, 32'h01);
    check("irq_clr", {31'b0, bus0.irq}, 32'h0);
    rd(0, 3'd3, 32'h00, "cap_cleared");
    drv_val0[0] = 1'b0;
    cycles(4);
    rd(0, 3'd3, 32'h00, "cap_fall_ignored");
    check("irq_fall", {31'b0, bus0.irq}, 32'h0);

    // Set/clear collision
    drv_val0[0] = 1'b1;
    cycles(4);
    check("irq_rise2", {31'b0, bus0.irq}, 32'h1);
    drv_val0[0] = 1'b0;
    cycles(4);
    drv_val0[0] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    wr(0, 3'd3, 32'h01);
    check("irq_collide", {31'b0, bus0.irq}, 32'h1);
    rd(0, 3'd3, 32'h01, "cap_collide");
    wr(0, 3'd4, 32'h00);
    rd(0, 3'd3, 32'h01, "cap_keep");

    // Falling capture
    wr(0, 3'd3, 32'h01);
    check("irq_clr2", {31'b0, bus0.irq}, 32'h0);
    wr(0, 3'd5, 32'h01);
    drv_val0[0] = 1'b0;
    cycles(4);
    rd(0, 3'd3, 32'h01, "cap_fall_en");
    check("irq_fall_en", {31'b0, bus0.irq}, 32'h1);

    // Debounce, D = 4
    wr(4, 3'd4, 32'h02);
    wr(4, 3'd2, 32'h02);
    drv_val4[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    drv_val4[1] = 1'b0;
    cycles(6);
    rd(4, 3'd3, 32'h00, "glitch_cap");
    rd(4, 3'd0, 32'h00, "glitch_data");
    check("glitch_irq", {31'b0, bus4.irq}, 32'h0);
    drv_val4[1] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("deb_e5", {31'b0, bus4.irq}, 32'h0);
    @(posedge clk);
    #1;
    check("deb_e6", {31'b0, bus4.irq}, 32'h1);
    rd(4, 3'd3, 32'h02, "deb_cap");
    rd(4, 3'd0, 32'h02, "deb_data");

    // Reset with pin2 held high
    drv_val4 = 8'h04;
    rst4 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst4 = 1'b0;
    check("rstpin_irq0", {31'b0, bus4.irq}, 32'h0);
    rd(4, 3'd2, 32'h00, "rstpin_mask");
    wr(4, 3'd4, 32'hFF);
    wr(4, 3'd2, 32'hFF);
    cycles(8);
    rd(4, 3'd3, 32'h00, "rstpin_cap");
    rd(4, 3'd0, 32'h04, "rstpin_data");
    check("rstpin_irq", {31'b0, bus4.irq}, 32'h0);

    cycles(3);
    checks++;
    if (exp_q0.size() != 0 || exp_q4.size() != 0) begin
      errors++;
      $display("FAIL pending_reads: got %0d expected 0", exp_q0.size() + exp_q4.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
